// File: rtl/mio_responder.sv
// mio_responder -- data-side memory/IO responder for the CPU MEM stage.
//
// Serves each request in a single cycle. Loads are combinational from a
// word-organised data RAM or a small peripheral window. Stores commit at
// the clock edge.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   mem_w              store strobe for the current request
//   Addr_out[31:0]     byte address
//   Data_out[31:0]     right-aligned store data
//   DMSize[2:0]        000 word, 001/010 half s/u, 011/100 byte s/u
//   sw[15:0], btn      switch levels and asynchronous button
//   Data_in[31:0]      sized, extended load data (same cycle)
//   MIO_ready          request accepted (high whenever not in reset)
//   INT, INT_data[1:0] interrupt request and source id (01 timer, 10 button)
//   led[15:0]          LED register
//
// Peripheral window at IO_BASE (word accesses only):
//   0x00 LED  0x04 SW  0x10 TCTRL{BIE,TIE,AUTO,EN}  0x14 TCMP  0x18 TCNT
//   0x1C STATUS{MISALIGN,BPEND,TPEND} (write-1-to-clear)
module mio_responder #(
    parameter int unsigned DM_DEPTH = 1024,
    parameter logic [31:0] IO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_w,
    input  logic [31:0] Addr_out,
    input  logic [31:0] Data_out,
    input  logic [2:0]  DMSize,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
    output logic        INT,
    output logic [1:0]  INT_data,
    output logic [15:0] led
);

    localparam int unsigned AW        = $clog2(DM_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DM_DEPTH);

    localparam logic [2:0] SZ_WORD   = 3'd0;
    localparam logic [2:0] SZ_HALF_S = 3'd1;
    localparam logic [2:0] SZ_HALF_U = 3'd2;
    localparam logic [2:0] SZ_BYTE_S = 3'd3;
    localparam logic [2:0] SZ_BYTE_U = 3'd4;

    localparam logic [2:0] OFF_LED    = 3'd0;
    localparam logic [2:0] OFF_SW     = 3'd1;
    localparam logic [2:0] OFF_TCTRL  = 3'd4;
    localparam logic [2:0] OFF_TCMP   = 3'd5;
    localparam logic [2:0] OFF_TCNT   = 3'd6;
    localparam logic [2:0] OFF_STATUS = 3'd7;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] mem [DM_DEPTH];

    logic [15:0] led_q, led_d;
    logic [3:0]  tctrl_q, tctrl_d;      // {BIE, TIE, AUTO, EN}
    logic [31:0] tcmp_q, tcmp_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic [2:0]  status_q, status_d;    // {MISALIGN, BPEND, TPEND}
    logic        btn_s1_q, btn_s2_q, btn_prev_q;
    logic [15:0] sw_s1_q, sw_s2_q;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic          is_word, is_half, is_byte, aligned, misalign;
    logic          ram_acc, io_acc, ram_we, io_we;
    logic [AW-1:0] ram_idx;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;

    assign is_word = (DMSize == SZ_WORD);
    assign is_half = (DMSize == SZ_HALF_S) || (DMSize == SZ_HALF_U);
    assign is_byte = (DMSize == SZ_BYTE_S) || (DMSize == SZ_BYTE_U);

    // aligned is false for unused DMSize codes, so they access nothing.
    assign aligned  = is_byte || (is_half && !Addr_out[0]) ||
                      (is_word && (Addr_out[1:0] == 2'b00));
    assign misalign = (is_word || is_half || is_byte) && !aligned;

    assign ram_acc = (Addr_out < RAM_BYTES) && aligned;
    assign io_acc  = (Addr_out[31:5] == IO_BASE[31:5]) && is_word && aligned;
    assign ram_we  = mem_w && ram_acc && !reset;
    assign io_we   = mem_w && io_acc;
    assign ram_idx = Addr_out[AW+1:2];

    // Replicate store data across lanes; lane_en picks which lanes land.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        lane_en   = 4'b0000;
        lane_data = Data_out;
        if (is_byte) begin
            lane_en   = 4'b0001 << Addr_out[1:0];
            lane_data = {4{Data_out[7:0]}};
        end else if (is_half) begin
            lane_en   = Addr_out[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{Data_out[15:0]}};
        end else if (is_word) begin
            lane_en   = 4'b1111;
        end
    end

    // NOTE: RAM contents have no reset; only the peripheral registers do.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && lane_en[i]) begin
                mem[ram_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [31:0] ram_word, byte_shift, io_rdata;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    assign ram_word   = mem[ram_idx];
    assign byte_shift = ram_word >> {Addr_out[1:0], 3'b000};
    assign byte_sel   = byte_shift[7:0];
    assign half_sel   = Addr_out[1] ? ram_word[31:16] : ram_word[15:0];

    always_comb begin
        io_rdata = 32'h0;
        case (Addr_out[4:2])
            OFF_LED:    io_rdata = {16'h0, led_q};
            OFF_SW:     io_rdata = {16'h0, sw_s2_q};
            OFF_TCTRL:  io_rdata = {28'h0, tctrl_q};
            OFF_TCMP:   io_rdata = tcmp_q;
            OFF_TCNT:   io_rdata = tcnt_q;
            OFF_STATUS: io_rdata = {29'h0, status_q};
            default:    io_rdata = 32'h0;
        endcase
    end

    always_comb begin
        Data_in = 32'h0;
        if (ram_acc) begin
            case (DMSize)
                SZ_HALF_S: Data_in = {{16{half_sel[15]}}, half_sel};
                SZ_HALF_U: Data_in = {16'h0, half_sel};
                SZ_BYTE_S: Data_in = {{24{byte_sel[7]}}, byte_sel};
                SZ_BYTE_U: Data_in = {24'h0, byte_sel};
                default:   Data_in = ram_word;
            endcase
        end else if (io_acc) begin
            Data_in = io_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Peripheral next state
    // ------------------------------------------------------------------
    logic       tpend_set, bpend_set;
    logic [2:0] w1c;

    always_comb begin
        led_d     = led_q;
        tctrl_d   = tctrl_q;
        tcmp_d    = tcmp_q;
        tcnt_d    = tcnt_q;
        tpend_set = 1'b0;
        w1c       = 3'b000;

        if (tctrl_q[0]) begin
            if (tcnt_q == tcmp_q) begin
                tpend_set = 1'b1;
                if (tctrl_q[1]) tcnt_d     = 32'h0;
                else            tctrl_d[0] = 1'b0;   // one-shot disarms itself
            end else begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end

        // Software writes come after the timer update so they override it.
        if (io_we) begin
            case (Addr_out[4:2])
                OFF_LED:    led_d   = Data_out[15:0];
                OFF_TCTRL:  tctrl_d = Data_out[3:0];
                OFF_TCMP:   tcmp_d  = Data_out;
                OFF_TCNT:   tcnt_d  = Data_out;
                OFF_STATUS: w1c     = Data_out[2:0];
                default:    ;
            endcase
        end

        bpend_set = btn_s2_q && !btn_prev_q;
        // Set terms are OR-ed after the clear so a coincident event wins.
        status_d  = (status_q & ~w1c) | {mem_w && misalign, bpend_set, tpend_set};
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            led_q      <= 16'h0;
            tctrl_q    <= 4'h0;
            tcmp_q     <= 32'hFFFF_FFFF;
            tcnt_q     <= 32'h0;
            status_q   <= 3'b000;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            sw_s1_q    <= 16'h0;
            sw_s2_q    <= 16'h0;
        end else begin
            led_q      <= led_d;
            tctrl_q    <= tctrl_d;
            tcmp_q     <= tcmp_d;
            tcnt_q     <= tcnt_d;
            status_q   <= status_d;
            btn_s1_q   <= btn;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
            sw_s1_q    <= sw;
            sw_s2_q    <= sw_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic t_irq, b_irq;

    assign t_irq     = status_q[0] && tctrl_q[2];
    assign b_irq     = status_q[1] && tctrl_q[3];
    assign INT       = t_irq || b_irq;
    assign INT_data  = t_irq ? 2'b01 : (b_irq ? 2'b10 : 2'b00);
    assign MIO_ready = !reset;
    assign led       = led_q;

endmodule
